// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: default widths, boot vector and the
// {pc, inst} record handed from fetch to decode.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  // Boot ROM vector; first fetch after reset.
  localparam logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, inst SRAM read port and the
// valid/ready instruction stream towards decode.
// master = fetch queue side, slave = environment (core / SRAM) side.
interface inst_fetch_queue_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DATA_W = mips_pkg::INST_W
);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_rdata;

  modport master (
    input  redirect_valid, redirect_pc, out_ready, inst_sram_rdata,
    output out_valid, out_pc, out_inst, inst_sram_en, inst_sram_addr
  );

  modport slave (
    output redirect_valid, redirect_pc, out_ready, inst_sram_rdata,
    input  out_valid, out_pc, out_inst, inst_sram_en, inst_sram_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// Head is read straight from the storage array so out_valid/out_pc/out_inst
// depend only on registered state. clear empties the queue on the same edge.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; clear beats any same-cycle push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_rd) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(do_rd);
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Upstream credit accounting must never let a response hit a full queue.
  no_write_when_full: assert property (@(posedge clk) disable iff (!resetn)
    !(wr_en && full && !clear));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues sequential word reads to a
// fixed-latency inst SRAM, tracks them through a SRAM_LAT-deep shift
// register and queues returned words with their PC for decode.
// A redirect restarts fetch at the new PC in the same cycle and drops
// everything queued or in flight.
module inst_fetch_queue
  import mips_pkg::*;
#(
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int DATA_W   = mips_pkg::INST_W,
  parameter int DEPTH    = 4,
  parameter int SRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input logic                clk,
  input logic                resetn,
  inst_fetch_queue_if.master bus
);

  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int CNT_W  = $clog2(DEPTH + SRAM_LAT + 1);
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic [ADDR_W-1:0]   fetch_pc_next;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                issue;
  logic                credit_ok;
  logic [SRAM_LAT-1:0] stage_valid_reg;
  logic [SRAM_LAT-1:0] stage_valid_next;
  logic [ADDR_W-1:0]   stage_pc_reg [SRAM_LAT];
  logic [CNT_W-1:0]    inflight_count;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty;
  logic                fifo_wr;
  logic                fifo_rd;
  logic [ENT_W-1:0]    fifo_wr_data;
  logic [ENT_W-1:0]    fifo_rd_data;

  // Number of reads still travelling through the SRAM pipeline.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < SRAM_LAT; i++) begin
      inflight_count = inflight_count + CNT_W'(stage_valid_reg[i]);
    end
  end

  // Issue only when every outstanding read has a guaranteed FIFO slot;
  // a pop this cycle is not counted, which keeps the credit check registered-only.
  always_comb begin
    credit_ok     = (CNT_W'(fifo_count) + inflight_count) < CNT_W'(DEPTH);
    issue         = resetn & (credit_ok | bus.redirect_valid);
    fetch_addr    = bus.redirect_valid ? (bus.redirect_pc & WORD_MASK) : fetch_pc_reg;
    fetch_pc_next = issue ? (fetch_addr + ADDR_W'(4)) : fetch_pc_reg;
  end

  // Tracker valid bits: stage 0 takes this cycle's issue (including the
  // redirect target); older stages are killed by a redirect.
  assign stage_valid_next[0] = issue;
  for (genvar gi = 1; gi < SRAM_LAT; gi++) begin : g_stage
    assign stage_valid_next[gi] = stage_valid_reg[gi-1] & ~bus.redirect_valid;
  end

  // Fetch PC and tracker valid bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_reg    <= RESET_PC;
      stage_valid_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      stage_valid_reg <= stage_valid_next;
    end
  end

  // Tracker PCs shift alongside the valid bits; meaningful only where valid.
  always_ff @(posedge clk) begin
    stage_pc_reg[0] <= fetch_addr;
    for (int i = 1; i < SRAM_LAT; i++) begin
      stage_pc_reg[i] <= stage_pc_reg[i-1];
    end
  end

  // Response arriving for the oldest tracker stage; dropped on redirect.
  assign fifo_wr      = stage_valid_reg[SRAM_LAT-1] & ~bus.redirect_valid;
  assign fifo_wr_data = {stage_pc_reg[SRAM_LAT-1], bus.inst_sram_rdata};
  assign fifo_rd      = ~fifo_empty & bus.out_ready;

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (bus.redirect_valid),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.out_valid      = ~fifo_empty;
  assign bus.out_pc         = fifo_rd_data[ENT_W-1:DATA_W];
  assign bus.out_inst       = fifo_rd_data[DATA_W-1:0];
  assign bus.inst_sram_en   = issue;
  assign bus.inst_sram_addr = fetch_addr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an SRAM model and an
// in-order scoreboard of expected {pc, inst} deliveries.
module tb_inst_fetch_queue;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LAT    = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .SRAM_LAT (LAT),
    .RESET_PC (RST_PC)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // SRAM contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h3C3C_C3C3;
  endfunction

  // Fixed-latency SRAM model.
  logic [31:0] sram_pipe [LAT];
  always @(posedge clk) begin
    sram_pipe[0] <= bus.inst_sram_en ? bus.inst_sram_addr : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign bus.inst_sram_rdata = mem_word(sram_pipe[LAT-1]);

  exp_t exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int req_count = 0;
  int pop_count = 0;
  int rq0;
  int p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Runs mid-cycle: pop/compare a delivered word, then apply flush and push new request.
  task automatic monitor();
    exp_t e;
    if (!resetn) begin
      exp_q.delete();
      return;
    end
    if (bus.out_valid && bus.out_ready) begin
      pop_count++;
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_empty: observed out_pc 0x%08h expected no delivery", bus.out_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.out_pc, e.pc);
        chk("sb_inst", bus.out_inst, e.inst);
        $display("deliver pc=0x%08h inst=0x%08h", bus.out_pc, bus.out_inst);
      end
    end
    if (bus.redirect_valid) exp_q.delete();
    if (bus.inst_sram_en) begin
      req_count++;
      exp_q.push_back('{pc: bus.inst_sram_addr, inst: mem_word(bus.inst_sram_addr)});
    end
  endtask

  // Advance one cycle: monitor the current cycle, land 1 time unit after the next edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    // Reset state.
    repeat (3) tick();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sram_en", 32'(bus.inst_sram_en), 32'd0);

    // 1: streaming from the reset vector, one request and one delivery per cycle.
    tick(); resetn = 1'b1; #1;
    chk("boot_en", 32'(bus.inst_sram_en), 32'd1);
    chk("boot_addr", bus.inst_sram_addr, RST_PC);
    chk("boot_valid0", 32'(bus.out_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick(); #1;
      chk("stream_en", 32'(bus.inst_sram_en), 32'd1);
      chk("stream_addr", bus.inst_sram_addr, RST_PC + 32'(4 * k));
      chk("stream_valid", 32'(bus.out_valid), (k >= LAT + 1) ? 32'd1 : 32'd0);
    end

    // 2: decode stalled from a fresh redirect; exactly DEPTH requests.
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_2000; bus.out_ready = 1'b0; #1;
    chk("stall_redir_addr", bus.inst_sram_addr, 32'h0000_2000);
    rq0 = req_count;
    tick(); bus.redirect_valid = 1'b0; #1;
    repeat (3) tick();
    #1;
    chk("stall_head_pc_a", bus.out_pc, 32'h0000_2000);
    repeat (8) tick();
    #1;
    chk("stall_req_total", 32'(req_count - rq0), 32'(DEPTH));
    chk("stall_en_low", 32'(bus.inst_sram_en), 32'd0);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_head_pc_b", bus.out_pc, 32'h0000_2000);
    chk("stall_head_inst", bus.out_inst, mem_word(32'h0000_2000));
    tick(); bus.out_ready = 1'b1; #1;
    chk("release_pc0", bus.out_pc, 32'h0000_2000);
    tick(); #1;
    chk("release_pc1", bus.out_pc, 32'h0000_2004);
    repeat (5) begin
      tick(); #1;
      chk("refill_en", 32'(bus.inst_sram_en), 32'd1);
    end

    // 3: redirect with LAT reads in flight, head not taken this cycle.
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_1003; bus.out_ready = 1'b0; #1;
    chk("redir_en", 32'(bus.inst_sram_en), 32'd1);
    chk("redir_addr", bus.inst_sram_addr, 32'h8000_1000);
    tick(); bus.redirect_valid = 1'b0; bus.out_ready = 1'b1; #1;
    chk("redir_next_addr", bus.inst_sram_addr, 32'h8000_1004);
    chk("redir_gap1", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("redir_gap2", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("redir_arrive_valid", 32'(bus.out_valid), 32'd1);
    chk("redir_arrive_pc", bus.out_pc, 32'h8000_1000);
    repeat (4) tick();

    // 4: redirect coinciding with a completed handshake.
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_4000; #1;
    chk("coinc_valid", 32'(bus.out_valid), 32'd1);
    p0 = pop_count;
    tick(); bus.redirect_valid = 1'b0; #1;
    chk("coinc_gap1", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("coinc_gap2", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("coinc_pops", 32'(pop_count - p0), 32'd1);
    chk("coinc_pc", bus.out_pc, 32'h0000_4000);
    repeat (3) tick();

    // 5: address wrap at the top of the address space.
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8; #1;
    chk("wrap_addr0", bus.inst_sram_addr, 32'hFFFF_FFF8);
    tick(); bus.redirect_valid = 1'b0; #1;
    chk("wrap_addr1", bus.inst_sram_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_addr2", bus.inst_sram_addr, 32'h0000_0000);
    tick(); #1;
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFF8);
    repeat (4) tick();

    // 6: reset pulse with the FIFO partly filled.
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_3000; bus.out_ready = 1'b0; #1;
    tick(); bus.redirect_valid = 1'b0; #1;
    repeat (3) tick();
    #1;
    chk("half_valid", 32'(bus.out_valid), 32'd1);
    tick(); resetn = 1'b0; #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_en", 32'(bus.inst_sram_en), 32'd0);
    tick(); resetn = 1'b1; bus.out_ready = 1'b1; #1;
    chk("rerst_addr", bus.inst_sram_addr, RST_PC);
    chk("rerst_en", 32'(bus.inst_sram_en), 32'd1);
    chk("rerst_valid0", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("rerst_valid1", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("rerst_valid2", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("rerst_arrive_pc", bus.out_pc, RST_PC);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
